// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared, one-cycle-registered ALU.
// Round-robin on ties, one op in flight, result returned over a valid/ready handshake.
module alu_arbiter #(
  parameter int unsigned XPR_LEN      = 32,
  parameter int unsigned ALU_OP_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [ALU_OP_WIDTH-1:0] req0_op,
  input  logic [XPR_LEN-1:0]      req0_rs1,
  input  logic [XPR_LEN-1:0]      req0_rs2,

  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [ALU_OP_WIDTH-1:0] req1_op,
  input  logic [XPR_LEN-1:0]      req1_rs1,
  input  logic [XPR_LEN-1:0]      req1_rs2,

  output logic                    resp0_valid,
  output logic [XPR_LEN-1:0]      resp0_data,
  input  logic                    resp0_ready,

  output logic                    resp1_valid,
  output logic [XPR_LEN-1:0]      resp1_data,
  input  logic                    resp1_ready,

  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic [XPR_LEN-1:0]      alu_rs1,
  output logic [XPR_LEN-1:0]      alu_rs2,
  output logic                    alu_enable,
  input  logic [XPR_LEN-1:0]      alu_rd,

  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CAPT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [ALU_OP_WIDTH-1:0]   op_q, op_d;
  logic [XPR_LEN-1:0]        rs1_q, rs1_d;
  logic [XPR_LEN-1:0]        rs2_q, rs2_d;
  logic [XPR_LEN-1:0]        result_q, result_d;
  logic                      owner_q, owner_d;
  logic                      last_grant_q, last_grant_d;

  logic                      gnt0_c, gnt1_c;
  logic                      resp_ready_c;

  // Tie goes to whichever requester was not served last.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (state_q == S_IDLE && !rst) begin
      gnt0_c = req0_valid && (!req1_valid || last_grant_q);
      gnt1_c = req1_valid && (!req0_valid || !last_grant_q);
    end
  end

  assign req0_ready   = gnt0_c;
  assign req1_ready   = gnt1_c;
  assign resp_ready_c = owner_q ? resp1_ready : resp0_ready;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    result_d     = result_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (gnt0_c) begin
          op_d         = req0_op;
          rs1_d        = req0_rs1;
          rs2_d        = req0_rs2;
          owner_d      = 1'b0;
          last_grant_d = 1'b0;
          state_d      = S_EXEC;
        end else if (gnt1_c) begin
          op_d         = req1_op;
          rs1_d        = req1_rs1;
          rs2_d        = req1_rs2;
          owner_d      = 1'b1;
          last_grant_d = 1'b1;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: state_d = S_CAPT;
      S_CAPT: begin
        result_d = alu_rd;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (resp_ready_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      result_q     <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      result_q     <= result_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Operands stay on the ALU bus between ops; only the enable pulses.
  assign alu_op     = op_q;
  assign alu_rs1    = rs1_q;
  assign alu_rs2    = rs2_q;
  assign alu_enable = (state_q == S_EXEC);
  assign busy       = (state_q != S_IDLE);

  assign resp0_valid = (state_q == S_RESP) && !owner_q;
  assign resp1_valid = (state_q == S_RESP) &&  owner_q;
  assign resp0_data  = resp0_valid ? result_q : '0;
  assign resp1_data  = resp1_valid ? result_q : '0;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter XPR_LEN, default 32, operand/result width.
REQ-002 SHALL have parameter ALU_OP_WIDTH, default 4, ALU opcode width (same encoding as the ALU_OP_* defines).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req0_valid / req1_valid  input  1 each  requester N has an op pending.
REQ-006 SHALL have port req0_ready / req1_ready  output  1 each  op from requester N accepted this cycle.
REQ-007 SHALL have port reqN_op  input  ALU_OP_WIDTH, reqN_rs1  input  XPR_LEN, and reqN_rs2  input  XPR_LEN, for N=0,1; each is the op/operands of requester N.
REQ-008 SHALL have port respN_valid  output  1, respN_data  output  XPR_LEN, and respN_ready  input  1, for N=0,1; these form the result handshake to requester N.
REQ-009 SHALL have port alu_op  output  ALU_OP_WIDTH, alu_rs1  output  XPR_LEN, alu_rs2  output  XPR_LEN, and alu_enable  output  1, which drive the shared ALU.
REQ-010 SHALL have port alu_rd  input  XPR_LEN, the ALU result, registered inside the ALU one cycle after alu_enable.
REQ-011 SHALL have port busy  output  1, high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, CAPT, RESP; one op outstanding at most.
REQ-013 IDLE: grant = sole valid requester; if both valid, grant the one not granted last (last_grant bit); none valid -> no grant.
REQ-014 IDLE: reqN_ready = 1 only for the granted requester, combinationally; the other ready = 0; both 0 outside IDLE.
REQ-015 On reqN_valid && reqN_ready: latch op, rs1, rs2, and owner=N; set last_grant=N; go to EXEC.
REQ-016 EXEC: alu_enable=1; alu_op/alu_rs1/alu_rs2 = latched values; go to CAPT unconditionally.
REQ-017 Outside EXEC: alu_enable=0; alu_op/alu_rs1/alu_rs2 = latched values (held, not zeroed).
REQ-018 CAPT: latch alu_rd into result register; go to RESP.
REQ-019 RESP: resp<owner>_valid=1 and resp<owner>_data=result; the non-owner valid=0; data stable while valid.
REQ-020 RESP: on resp<owner>_ready, return to IDLE; without ready, hold RESP indefinitely (no timeout).
REQ-021 Latency: accept edge -> resp_valid high 3 cycles later; minimum issue interval 4 cycles.
REQ-022 The result is passed through unmodified (no width change); undefined opcodes are forwarded, and the ALU returns 0 for them.
REQ-023 respN_data SHALL read 0 whenever respN_valid=0.
REQ-024 Requester valid deasserting before grant: no state change; a request arriving in non-IDLE states waits (ready=0).
REQ-025 respN_ready while respN_valid=0 is ignored.

Reset
REQ-026 rst=1 at a clock edge: state=IDLE; last_grant=1, so req0 wins the first tie; latched op/operands/result=0.
REQ-027 During and immediately after reset: all ready=0 while rst=1, all resp valid=0, alu_enable=0, busy=0.
REQ-028 Reset mid-operation (any state): the outstanding op is discarded, with no response ever issued for it.

Verification
REQ-029 Single op: req0 ALU_OP_ADD rs1=5 rs2=7, resp0_ready=1 -> req0_ready in cycle 0; alu_enable in cycle 1; resp0_valid in cycle 3 with data=12; IDLE in cycle 4.
REQ-030 Tie: both valid every cycle after reset (req0 SUB 10-3, req1 XOR 0xF0^0x0F) -> order req0 (7), req1 (0xFF), req0, alternating.
REQ-031 Backpressure: resp1_ready=0 for 5 cycles in RESP -> resp1_valid and data held constant; req0 pending stays ready=0; on ready=1, IDLE next cycle, then req0 granted.
REQ-032 Reset in EXEC and in RESP -> next cycle busy=0, resp valids=0, alu_enable=0; that op never responds.
REQ-033 Signed/shift pass-through: req1 ALU_OP_SRA rs1=0x80000000 rs2=4 -> resp1_data=0xF8000000; ALU_OP_SLT rs1=-1 rs2=1 -> 1.
REQ-034 Undefined opcode from req0 -> resp0_valid with data=0; FSM returns to IDLE normally.
